// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver feeding an async FIFO write port.
// Optional even-parity checking and the parity_err port are enabled by UART_RX_PARITY_EN.
module uart_rx_frontend #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 rx,
    input  logic                 full,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    state_t state, state_next;
    logic [1:0] sync;
    logic rx_s;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic at_last, stop_smp, par_bad;
    logic valid_d, ferr_d, ovr_d;
    assign rx_s     = sync[1];
    assign at_last  = cnt == LAST;
    assign stop_smp = state == STOP && at_last;
`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = ^{shreg, par_bit};
`else
    assign par_bad = 1'b0;
`endif
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync      <= {sync[0], rx};
            state     <= state_next;
            cnt       <= (state_next != state || at_last) ? '0 : cnt + 1'b1;
            bit_cnt   <= state == DATA ? bit_cnt + BW'(at_last) : '0;
            shreg     <= (state == DATA && at_last) ? {rx_s, shreg[DATA_BITS-1:1]} : shreg;
            rx_data   <= valid_d ? shreg : rx_data;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
            overrun   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bit    <= (state == PARITY && at_last) ? rx_s : par_bit;
            parity_err <= stop_smp && rx_s && par_bad;
`endif
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = rx_s ? IDLE : START;
            START:     if (cnt == HALF) state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (at_last && bit_cnt == BLAST) state_next = PARITY;
            PARITY:    if (at_last) state_next = STOP;
`else
            DATA:      if (at_last && bit_cnt == BLAST) state_next = STOP;
`endif
            STOP:      if (at_last) state_next = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end
    // Error priority: a low stop bit masks parity, and parity masks overrun.
    always_comb begin
        busy    = state != IDLE;
        ferr_d  = stop_smp && !rx_s;
        ovr_d   = stop_smp && rx_s && !par_bad && full;
        valid_d = stop_smp && rx_s && !par_bad && !full;
    end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed bench for uart_rx_frontend (8 data bits, 16 clocks per bit).
module tb_uart_rx_frontend;
    localparam int CPB = 16;
    logic wr_clk, wr_rst, rx, full;
    logic [7:0] rx_data;
    logic rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`endif
    int tests = 0, fails = 0;
    int n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, excl_bad = 0;
    logic [7:0] got[$];

    uart_rx_frontend #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .rx(rx), .full(full),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        int p;
        p = int'(rx_valid === 1'b1) + int'(frame_err === 1'b1) + int'(overrun === 1'b1);
`ifdef UART_RX_PARITY_EN
        p += int'(parity_err === 1'b1);
        if (parity_err === 1'b1) n_perr++;
`endif
        if (rx_valid === 1'b1) begin
            n_valid++;
            got.push_back(rx_data);
        end
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
        if (p > 1) excl_bad++;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge wr_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
    endtask

    task automatic test_reset;
        rx = 1'b1;
        full = 1'b0;
        wr_rst = 1'b1;
        repeat (3) @(negedge wr_clk);
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        wr_rst = 1'b0;
        repeat (100) @(negedge wr_clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
        tests++; if (n_valid + n_ferr + n_ovr !== 0) begin fails++; $display("FAIL idle_pulses: got %0d want 0", n_valid + n_ferr + n_ovr); end
    endtask

    task automatic test_single;
        int v0 = n_valid, e0 = n_ferr + n_ovr;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL single_count: got %0d want 1", n_valid - v0); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", rx_data); end
        tests++; if (n_ferr + n_ovr - e0 !== 0) begin fails++; $display("FAIL single_errs: got %0d want 0", n_ferr + n_ovr - e0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int v0 = n_valid, q0 = got.size();
        logic [7:0] exp_d[3] = '{8'h00, 8'hFF, 8'h3C};
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_valid - v0 !== 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", n_valid - v0); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got.size() <= q0 + i) begin
                fails++; $display("FAIL b2b_data%0d: got none want %h", i, exp_d[i]);
            end else if (got[q0+i] !== exp_d[i]) begin
                fails++; $display("FAIL b2b_data%0d: got %h want %h", i, got[q0+i], exp_d[i]);
            end
        end
    endtask

    task automatic test_glitch_framing;
        int v0 = n_valid, f0 = n_ferr, q0;
        rx = 1'b0;
        repeat (4) @(negedge wr_clk);
        rx = 1'b1;
        repeat (20) @(negedge wr_clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b want 0", busy); end
        tests++; if (n_valid - v0 + n_ferr - f0 !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", n_valid - v0 + n_ferr - f0); end
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge wr_clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL break_busy: got %b want 1", busy); end
        rx = 1'b1;
        repeat (20) @(negedge wr_clk);
        tests++; if (n_ferr - f0 !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL ferr_novalid: got %0d want 0", n_valid - v0); end
        q0 = got.size();
        send_frame(8'h12, 1'b1);
        repeat (4) @(negedge wr_clk);
        tests++;
        if (got.size() != q0 + 1) begin
            fails++; $display("FAIL after_ferr_count: got %0d want 1", got.size() - q0);
        end else if (got[q0] !== 8'h12) begin
            fails++; $display("FAIL after_ferr_data: got %h want 12", got[q0]);
        end
    endtask

    task automatic test_overrun;
        int v0, o0;
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge wr_clk);
        v0 = n_valid;
        o0 = n_ovr;
        full = 1'b1;
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_ovr - o0 !== 1) begin fails++; $display("FAIL ovr_count: got %0d want 1", n_ovr - o0); end
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL ovr_novalid: got %0d want 0", n_valid - v0); end
        tests++; if (rx_data !== 8'h11) begin fails++; $display("FAIL ovr_hold: got %h want 11", rx_data); end
        full = 1'b0;
        send_frame(8'h33, 1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL post_ovr_count: got %0d want 1", n_valid - v0); end
        tests++; if (rx_data !== 8'h33) begin fails++; $display("FAIL post_ovr_data: got %h want 33", rx_data); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d = 8'hC3;
        int v0 = n_valid, e0 = n_ferr + n_ovr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (CPB / 2) @(negedge wr_clk);
        wr_rst = 1'b1;
        @(negedge wr_clk);
        wr_rst = 1'b0;
        rx = 1'b1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        repeat (CPB * 12) @(negedge wr_clk);
        tests++; if (n_valid - v0 + n_ferr + n_ovr - e0 !== 0) begin fails++; $display("FAIL midrst_pulses: got %0d want 0", n_valid - v0 + n_ferr + n_ovr - e0); end
        send_frame(8'h96, 1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL midrst_next_count: got %0d want 1", n_valid - v0); end
        tests++; if (rx_data !== 8'h96) begin fails++; $display("FAIL midrst_next_data: got %h want 96", rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        logic [7:0] d = 8'h07;
        int v0 = n_valid, p0 = n_perr;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_perr - p0 !== 1) begin fails++; $display("FAIL perr_count: got %0d want 1", n_perr - p0); end
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL perr_novalid: got %0d want 0", n_valid - v0); end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (4) @(negedge wr_clk);
        tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL par_ok_count: got %0d want 1", n_valid - v0); end
        tests++; if (rx_data !== 8'h07) begin fails++; $display("FAIL par_ok_data: got %h want 07", rx_data); end
        tests++; if (n_perr - p0 !== 1) begin fails++; $display("FAIL par_ok_noperr: got %0d want 1", n_perr - p0); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch_framing;
        test_overrun;
        test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        tests++; if (excl_bad !== 0) begin fails++; $display("FAIL exclusive: got %0d overlapping cycles want 0", excl_bad); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- UART receive front end for the write-clock domain of the async RX FIFO.
- Oversamples the asynchronous serial line, deserializes LSB-first frames and emits one-cycle write strobes plus data, intended to drive the FIFO write side's wr_en and data input directly.
- Honours the FIFO full flag: a frame that completes while full is dropped and flagged as overrun.

Parameters:
- DATA_BITS, 8: data bits per frame (5..8).
- CLKS_PER_BIT, 16: wr_clk cycles per bit period. Even, >= 8.

Ports:
- wr_clk  input  1  receive-domain clock.
- wr_rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line, idle high.
- full  input  1  FIFO full flag from the write side.
- rx_data  output  DATA_BITS  last accepted byte; right-aligned, LSB = first bit received.
- rx_valid  output  1  one-cycle write strobe; connects to the FIFO wr_en.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good frame dropped because full was high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock, synchronous active-high reset on wr_rst; all state updates on wr_clk rising edge.
  - While wr_rst is high: state = IDLE, bit counter = 0, cycle counter = 0.
  - Outputs: rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - Synchronizer flops reset to 1 (line idle).
  - Reset mid-frame abandons the frame; no strobe or error is produced.
- Input sync: rx passes through a 2-flop synchronizer; rx_s is the second stage.
- Cycle counter: counts 0..CLKS_PER_BIT-1. It clears on every state entry and on each bit sample.
- State machine:
  - IDLE: rx_s == 0 -> START.
  - START: at count == CLKS_PER_BIT/2-1, sample rx_s.
    - Sample 0 -> DATA; all later samples then land mid-bit.
    - Sample 1 -> IDLE (glitch rejected, no flag).
  - DATA: at count == CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift) and increment the bit counter. After DATA_BITS samples -> STOP (or PARITY when the optional feature is compiled in).
  - STOP: at count == CLKS_PER_BIT-1, sample rx_s.
    - Sample 1 and full == 0: rx_data <= shift register, rx_valid = 1 for exactly one cycle -> IDLE.
    - Sample 1 and full == 1: overrun = 1 for one cycle; rx_data unchanged; rx_valid stays 0 -> IDLE.
    - Sample 0: frame_err = 1 for one cycle, no strobe -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s == 1 -> IDLE. This rejects break conditions without retriggering.
- full is evaluated only in the stop-sample cycle; its value at other times is ignored.
- Latency: rx_valid, frame_err and overrun assert in the cycle after the stop-sample edge. The first rx_valid after a falling line edge arrives within 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: a start bit arriving immediately after the stop-bit midpoint is detected because the block returns to IDLE right after the stop sample. At most one strobe per frame.
- rx_valid, frame_err and overrun are mutually exclusive in any cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP samples one parity bit at count == CLKS_PER_BIT-1; even parity is checked.
  - New output port parity_err (1 bit) pulses for one cycle, in the same cycle a strobe would have occurred, when parity mismatches and the stop bit is 1. No rx_valid in that case.
  - Priority: frame_err > parity_err > overrun.
- Undefined: no PARITY state and no parity_err port. The frame is start + DATA_BITS + stop.

Test Plan:
- Reset/idle:
  - Stimulus: assert wr_rst 3 cycles with rx = 1, release, hold 100 cycles.
  - Response: all outputs stay 0; busy = 0.
- Single frame:
  - Stimulus: CLKS_PER_BIT = 16, full = 0; send 0xA5 (8N1).
  - Response: exactly one rx_valid pulse with rx_data = 0xA5; frame_err = overrun = 0.
- Back-to-back:
  - Stimulus: send 0x00, 0xFF, 0x3C with no idle gap between frames.
  - Response: three rx_valid pulses carrying 0x00, 0xFF, 0x3C in order.
- Glitch and framing:
  - Stimulus 1: drive a 4-cycle low pulse on idle rx.
    - Response: return to IDLE, no pulses.
  - Stimulus 2: send 0x55 with stop bit low, then hold low 40 cycles, then high.
    - Response: one frame_err pulse; no rx_valid; the next frame 0x12 is received correctly.
- Overrun:
  - Stimulus: receive 0x11, then hold full = 1 and send 0x22.
  - Response: overrun pulses once; no rx_valid; rx_data stays 0x11.
  - Stimulus: release full and send 0x33.
  - Response: rx_valid with 0x33.
- Reset mid-frame and parity (UART_RX_PARITY_EN):
  - Stimulus 1: assert wr_rst during data bit 4.
    - Response: no strobe; next frame decodes correctly.
  - Stimulus 2: send 0x07 with parity bit 0.
    - Response: parity_err pulses, no rx_valid.
  - Stimulus 3: send 0x07 with parity bit 1.
    - Response: rx_valid with 0x07.
